// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: round-robin scheduler for one DDR command port.
// Write commands keep the port through their data phase. A free-running refresh
// timer raises refresh requests, and these win at every grant boundary.
module ddr_cmd_sched #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int LW   = 8,
  parameter int IDW  = 2,
  parameter int RW   = 16
) (
  input  logic               osc_clk,
  input  logic               sys_rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*LW-1:0] req_len,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [AW-1:0]      cmd_addr,
  output logic               cmd_wr,
  output logic [LW-1:0]      cmd_len,
  output logic [IDW-1:0]     cmd_id,
  input  logic               wr_last,
  output logic               ref_req,
  input  logic               ref_ack,
  input  logic [RW-1:0]      cfg_ref_interval,
  output logic               ref_overflow,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_REF} state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_q;
  logic           cmd_valid_q, cmd_wr_q, ref_req_q;
  logic [AW-1:0]  cmd_addr_q;
  logic [LW-1:0]  cmd_len_q;
  logic [IDW-1:0] cmd_id_q;
  logic [RW-1:0]  ref_cnt_q, ref_cnt_d;
  logic           ref_pending_q, ref_pending_d;
  logic           ref_overflow_q, ref_overflow_d;

  logic           hi_found, lo_found, any_vld, grant, expire, ack_fire;
  logic [IDW-1:0] hi_sel, lo_sel, sel;
  logic [AW-1:0]  sel_addr;
  logic           sel_wr;
  logic [LW-1:0]  sel_len;

  // Round-robin pick: lowest valid index above rr, else lowest valid index at or below rr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) > rr_q) begin
          hi_found = 1'b1;
          hi_sel   = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_sel   = IDW'(i);
        end
      end
    end
    sel     = hi_found ? hi_sel : lo_sel;
    any_vld = hi_found | lo_found;
  end

  assign grant = (state_q == S_IDLE) && !ref_pending_q && any_vld;

  // One-hot capture pulse and selection mux for the winning requester's command fields.
  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_wr    = 1'b0;
    sel_len   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        req_ready[i] = grant;
        sel_addr     = req_addr[i*AW +: AW];
        sel_wr       = req_wr[i];
        sel_len      = req_len[i*LW +: LW];
      end
    end
  end

  assign expire   = (cfg_ref_interval != '0) && (ref_cnt_q == RW'(1));
  assign ack_fire = (state_q == S_REF) && ref_ack;

  // Refresh timer next state: a zero count loads the interval, and an expiry reloads it.
  always_comb begin
    ref_cnt_d      = ref_cnt_q;
    ref_pending_d  = ref_pending_q;
    ref_overflow_d = ref_overflow_q;
    if (cfg_ref_interval == '0) begin
      ref_cnt_d = '0;
    end else if (ref_cnt_q == '0 || expire) begin
      ref_cnt_d = cfg_ref_interval;
    end else begin
      ref_cnt_d = ref_cnt_q - RW'(1);
    end
    if (expire) begin
      ref_pending_d = 1'b1;
      if (ref_pending_q && !ack_fire) ref_overflow_d = 1'b1;
    end else if (ack_fire) begin
      ref_pending_d = 1'b0;
    end
  end

  // Refresh timer registers; they run in every FSM state.
  always_ff @(posedge osc_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ref_cnt_q      <= '0;
      ref_pending_q  <= 1'b0;
      ref_overflow_q <= 1'b0;
    end else begin
      ref_cnt_q      <= ref_cnt_d;
      ref_pending_q  <= ref_pending_d;
      ref_overflow_q <= ref_overflow_d;
    end
  end

  // Scheduler FSM with registered command and refresh outputs.
  always_ff @(posedge osc_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      rr_q        <= IDW'(NREQ - 1);
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_len_q   <= '0;
      cmd_id_q    <= '0;
      ref_req_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ref_pending_q) begin
            ref_req_q <= 1'b1;
            state_q   <= S_REF;
          end else if (any_vld) begin
            cmd_valid_q <= 1'b1;
            cmd_addr_q  <= sel_addr;
            cmd_wr_q    <= sel_wr;
            cmd_len_q   <= sel_len;
            cmd_id_q    <= sel;
            rr_q        <= sel;
            state_q     <= S_CMD;
          end
        end
        S_CMD: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= cmd_wr_q ? S_WDATA : S_IDLE;
          end
        end
        S_WDATA: begin
          if (wr_last) state_q <= S_IDLE;
        end
        S_REF: begin
          if (ref_ack) begin
            ref_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_wr       = cmd_wr_q;
  assign cmd_len      = cmd_len_q;
  assign cmd_id       = cmd_id_q;
  assign ref_req      = ref_req_q;
  assign ref_overflow = ref_overflow_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/ddr_cmd_sched.md
Name: ddr_cmd_sched

Overview:
- Schedules the single DDR controller command port, bound at the top level, among NREQ requesters.
- Grants requesters in round-robin order.
- Holds the port for the whole write-data phase of a write.
- Inserts periodic refresh requests, which take priority at grant boundaries.
- Sits between the SoC masters' command channels and the DDR controller command/refresh interface, clocked by the board oscillator clock.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 32, command address width
- LW, 8, burst length field width (value = beats-1)
- IDW, 2, requester id width (must be >= clog2(NREQ))
- RW, 16, refresh interval counter width

Ports:
- osc_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  one-hot, single-cycle capture pulse
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wr  in  NREQ  1 = write, 0 = read
- req_len  in  NREQ*LW  packed burst lengths
- cmd_valid  out  1  command to DDR controller valid
- cmd_ready  in  1  DDR controller accepts command
- cmd_addr  out  AW  registered address
- cmd_wr  out  1  registered direction
- cmd_len  out  LW  registered length
- cmd_id  out  IDW  granted requester index
- wr_last  in  1  pulse on final accepted write-data beat of current write
- ref_req  out  1  refresh request to DDR controller
- ref_ack  in  1  refresh accepted
- cfg_ref_interval  in  RW  cycles between refreshes; 0 disables refresh
- ref_overflow  out  1  sticky: refresh interval expired while previous refresh still pending
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - All outputs 0; cmd_* fields 0.
  - FSM=IDLE; rr pointer (last granted) = NREQ-1, so requester 0 has first priority.
  - Refresh counter = 0, ref_pending = 0.
- Refresh timer:
  - If cfg_ref_interval == 0, the counter holds 0 and never sets ref_pending.
  - Otherwise it counts down. On reaching 1 it sets ref_pending next cycle and reloads cfg_ref_interval. The first expiry is cfg_ref_interval cycles after the first nonzero-config cycle, loading from 0.
  - An expiry while ref_pending=1 sets ref_overflow; ref_overflow clears only on reset.
  - The counter runs in every state.
- FSM states: IDLE, CMD, WDATA, REF.
- IDLE:
  - If ref_pending -> REF, with ref_req=1 from the next cycle. Refresh beats requests when both are present.
  - Else if any req_valid: select the first valid index searching rr+1, rr+2, ... modulo NREQ.
  - In the same cycle, assert req_ready[sel] (combinational, one cycle) and register addr/wr/len/id.
  - Next cycle cmd_valid=1; update rr=sel; -> CMD. Latency from req_valid to cmd_valid is 1 cycle when idle.
- CMD:
  - cmd_valid and cmd_* are held stable until cmd_ready.
  - On cmd_valid&&cmd_ready: cmd_valid=0 next cycle; -> WDATA if cmd_wr, else -> IDLE.
- WDATA:
  - No new grants; wait for wr_last, then -> IDLE.
  - A wr_last in any state other than WDATA is ignored.
- REF:
  - ref_req=1 until ref_ack.
  - On ref_ack: ref_req=0 next cycle, clear ref_pending, -> IDLE.
  - If an expiry coincides with ref_ack, ref_pending stays set and ref_overflow is not set.
- Back-to-back:
  - IDLE is always visited for one cycle between grants.
  - Minimum spacing is 2 cycles per read command when cmd_ready is held high.
- req_ready is never asserted outside IDLE, and at most one bit is set.
- A requester dropping req_valid before being granted is legal; no state is kept per requester.
- Asynchronous sys_rst mid-transaction returns everything to reset values immediately. An in-flight command is abandoned, and the DDR side must also be reset.

Test Plan:
- Arbitration order:
  - Stimulus: reset, cfg_ref_interval=0, all 4 req_valid held high as reads (len=3), cmd_ready=1.
  - Required response: cmd_id sequence 0,1,2,3,0; req_ready pulses one-hot every 2 cycles; first cmd_valid 1 cycle after first req_valid.
- Write hold:
  - Stimulus: req1 write len=7, req2 read pending, wr_last after 8 cycles.
  - Required response: req_ready[2] stays low until the cycle after the FSM returns to IDLE; busy=1 throughout WDATA.
- Backpressure:
  - Stimulus: cmd_ready low for 5 cycles with req0 granted.
  - Required response: cmd_valid, cmd_addr, cmd_len and cmd_id stable all 5 cycles; cmd_valid drops 1 cycle after the handshake.
- Refresh priority:
  - Stimulus: cfg_ref_interval=20, continuous reads.
  - Required response: ref_req asserts at the first IDLE after ref_pending is set; no req_ready while ref_req=1; ref_ack delayed 3 cycles -> ref_req low next cycle, then grants resume at rr+1.
- Overflow:
  - Stimulus: cfg_ref_interval=4, ref_ack tied 0.
  - Required response: ref_overflow=1 after the second expiry and stays 1; reset clears it.
- Async reset:
  - Stimulus: sys_rst asserted mid-WDATA, between clock edges.
  - Required response: busy, cmd_valid and ref_req go 0 without waiting for an osc_clk edge; after release, requester 0 has first priority.
